// File: rtl/default_reset_sequencer.sv
// Ordered reset release: async assert, synchronized and stretched deassert, one output per GAP_CYCLES.
// Optional software re-run handshake compiled in with `define DEFAULT_RESET_SEQ_SW_REQ_EN.

module default_reset_sequencer_lane (
    input  logic CLK_IN,
    input  logic RESET,
    input  logic clr,
    input  logic set,
    output logic rel
);

    always_ff @(posedge CLK_IN or negedge RESET) begin
        if (!RESET)   rel <= 1'b0;
        else if (clr) rel <= 1'b0;
        else if (set) rel <= 1'b1;
    end

endmodule

module default_reset_sequencer #(
    parameter int NUM_OUTPUTS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   CLK_IN,
    input  logic                   RESET,
    output logic [NUM_OUTPUTS-1:0] RST_OUT_N,
    output logic                   RESET_DONE,
    input  logic                   SW_RST_REQ,
    output logic                   SW_RST_ACK
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(NUM_OUTPUTS + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUTPUTS - 1);

    localparam logic [2:0] ST_IN_RESET = 3'd0;
    localparam logic [2:0] ST_SYNC     = 3'd1;
    localparam logic [2:0] ST_HOLD     = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    logic [2:0]             state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [IW-1:0]          idx, idx_nxt;
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync_rise;
    logic [NUM_OUTPUTS-1:0] release_set;
    logic                   release_clr;
    logic                   sw_accept;
    logic                   reset_done;

    // HOLD is entered on the same edge the synchronizer output rises, so bit 0
    // lands exactly HOLD_CYCLES edges later.
    assign sync_rise = sync_pipe[SYNC_STAGES-2] & ~sync_pipe[SYNC_STAGES-1];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        release_set = '0;
        release_clr = 1'b0;
        case (state)
            ST_IN_RESET, ST_SYNC: begin
                if (sync_rise) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_SYNC;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    release_set[0] = 1'b1;
                    cnt_nxt        = '0;
                    idx_nxt        = IW'(1);
                    state_nxt      = (NUM_OUTPUTS == 1) ? ST_DONE : ST_RELEASE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt == GAP_LAST) begin
                    release_set = NUM_OUTPUTS'(1) << idx;
                    cnt_nxt     = '0;
                    idx_nxt     = idx + 1'b1;
                    if (idx == IDX_LAST) state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                if (sw_accept) begin
                    release_clr = 1'b1;
                    state_nxt   = ST_HOLD;
                    cnt_nxt     = '0;
                    idx_nxt     = '0;
                end
            end
            default: state_nxt = ST_IN_RESET;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IN_RESET;
            cnt        <= '0;
            idx        <= '0;
            sync_pipe  <= '0;
            reset_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            sync_pipe  <= {sync_pipe[SYNC_STAGES-2:0], 1'b1};
            reset_done <= (state == ST_DONE) && !sw_accept;
        end
    end

    assign RESET_DONE = reset_done;

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_lane
        default_reset_sequencer_lane u_lane (
            .CLK_IN (CLK_IN),
            .RESET  (RESET),
            .clr    (release_clr),
            .set    (release_set[k]),
            .rel    (RST_OUT_N[k])
        );
    end

`ifdef DEFAULT_RESET_SEQ_SW_REQ_EN
    logic req_q;
    logic sw_ack;

    // Edge detector runs in every state so a request that rose earlier is never
    // mistaken for a fresh one once DONE is reached.
    assign sw_accept = (state == ST_DONE) && SW_RST_REQ && !req_q;

    always_ff @(posedge CLK_IN or negedge RESET) begin
        if (!RESET) begin
            req_q  <= 1'b0;
            sw_ack <= 1'b0;
        end else begin
            req_q  <= SW_RST_REQ;
            sw_ack <= sw_accept;
        end
    end

    assign SW_RST_ACK = sw_ack;
`else
    logic unused_sw_req;

    assign unused_sw_req = SW_RST_REQ;
    assign sw_accept     = 1'b0;
    assign SW_RST_ACK    = 1'b0;
`endif

endmodule
